usb_rx_frame_parser: RTL and testbench
======================================

Name: usb_rx_frame_parser

Overview:
- Byte-stream deframer placed directly downstream of the ftdi_245fifo RX stream (8-bit, rx_clk domain).
- Hunts for a sync byte, reads a length byte, and forwards the payload cut-through with a last marker.
- Verifies an XOR checksum and reports per-frame status.
- Keeps saturating error counters and aborts a frame after an inter-byte timeout.

Parameters:
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYC, 5000000: max idle cycles between bytes inside a frame (0.1 s at 50 MHz).
- CNT_W, 16: width of the saturating counters.

Ports:
- clk  in  1  RX stream clock (same clock as ftdi_245fifo rx_clk)
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  RX byte valid (from ftdi_245fifo rx_valid)
- in_ready  out  1  RX byte accept (to ftdi_245fifo rx_ready)
- in_data  in  8  RX byte
- out_valid  out  1  payload byte valid
- out_ready  in  1  downstream accept
- out_data  out  8  payload byte
- out_last  out  1  final payload byte of frame
- out_abort  out  1  one-cycle pulse: current frame truncated by timeout
- stat_valid  out  1  one-cycle frame-status pulse
- stat_ok  out  1  checksum matched (qualified by stat_valid)
- stat_len  out  8  LEN of the reported frame
- frame_cnt  out  CNT_W  good frames, saturating
- err_chk_cnt  out  CNT_W  checksum failures, saturating
- err_to_cnt  out  CNT_W  timeouts plus LEN==0 frames, saturating

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state HUNT; all counters 0; stat_valid/stat_ok/out_abort 0; stat_len 0; timer 0.
- Frame format: SYNC_BYTE, LEN (1..255), LEN payload bytes, CHK.
  - CHK = LEN XOR payload[0] XOR … XOR payload[LEN-1].
- A byte is accepted on in_valid & in_ready.
- State HUNT: in_ready=1.
  - Accepted byte == SYNC_BYTE → LEN.
  - Any other byte is discarded silently.
- State LEN: in_ready=1.
  - LEN==0 → HUNT; err_to_cnt++; stat_valid pulse with stat_ok=0, stat_len=0.
  - LEN>0 → PAYLOAD; remaining=LEN; xor_acc=LEN.
- State PAYLOAD: cut-through with zero latency; out_* is combinational from in_*.
  - out_valid = in_valid; out_data = in_data; in_ready = out_ready.
  - out_last = (remaining==1).
  - Each accepted byte: xor_acc ^= byte; remaining--.
  - Accepted byte with remaining==1 → CHK.
  - SYNC_BYTE inside the payload is ordinary data; there is no resync.
- State CHK: in_ready=1.
  - On accept, the next cycle pulses stat_valid with stat_ok=(byte==xor_acc) and stat_len=LEN, then → HUNT.
  - ok → frame_cnt++; else → err_chk_cnt++.
- Outside PAYLOAD: out_valid=0 and out_last=0.
- Timeout:
  - The timer clears on every accepted byte and is held at 0 in HUNT.
  - It increments each cycle with no accepted byte in LEN/PAYLOAD/CHK.
  - It freezes while in PAYLOAD with in_valid=1 and out_ready=0, so downstream back-pressure is not a timeout.
  - Timer reaching TIMEOUT_CYC → HUNT; err_to_cnt++; stat_valid pulse with stat_ok=0, stat_len=LEN.
  - If the timeout occurs in PAYLOAD, out_abort pulses the same cycle as stat_valid.
- Simultaneous byte accept and timer expiry: the byte wins and the timer clears.
- Counters saturate at all-ones; no wrap.
- Reset mid-frame: back to HUNT next cycle, no status pulse, no abort pulse. Counters clear.
- stat_valid has a 1-cycle latency after the CHK accept. Back-to-back frames are legal: SYNC may be accepted in the same cycle stat_valid is high.

Decomposition:
- Package usb_frame_pkg holds:
  - state enum {HUNT, LEN, PAYLOAD, CHK};
  - default SYNC_BYTE;
  - a saturating-increment function.
- One sub-module: sat_counter (CNT_W, inc, rst). It is instantiated three times.
- The FSM, timer and XOR accumulator stay in the top of this block.

Test Plan:
- Good frame: A5 03 11 22 33 CHK=03^11^22^33=0x03 → out bytes 11,22,33 with out_last on 33; stat_valid, stat_ok=1, stat_len=3; frame_cnt=1.
- Bad checksum: A5 02 10 20 FF → payload forwarded with last on 20; stat_ok=0; err_chk_cnt=1; frame_cnt unchanged.
- Garbage then frame, with back-pressure: 00 7E A5 01 A5 A4 with out_ready low for 10 cycles while A5 is presented → garbage discarded; payload A5 forwarded after the stall; no timeout; stat_ok=1.
- Timeout with TIMEOUT_CYC=100: A5 04 01 02 then idle 100 cycles → out_abort and stat_valid (ok=0, len=4) on the same cycle; err_to_cnt=1; the next A5 is accepted as a new frame.
- LEN zero and saturation with CNT_W=2: A5 00 repeated 5× → 5 stat pulses with ok=0; err_to_cnt saturates at 3.
- Reset mid-payload: assert rst after the 2nd byte of LEN=5 → state HUNT, all counters 0, no stat/abort pulse; a following good frame is parsed correctly.

Source files
------------

// File: rtl/usb_rx_frame_parser_pkg.sv
// Shared types and helpers for the USB RX frame parser: FSM states, status bundle, saturating increment.
// Pure declarations; no logic or latency of its own.
package usb_frame_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    CHK     = 2'd3
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef struct packed {
    logic       ok;
    logic [7:0] len;
  } stat_t;

  // Widened to 32 bits so any counter width up to 32 can share one helper.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/usb_rx_frame_parser_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
// Count is visible one cycle after inc; no backpressure.
module sat_counter
  import usb_frame_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc) cnt_d = CNT_W'(sat_inc(32'(cnt_q), 32'(CNT_MAX)));
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/usb_rx_frame_parser.sv
// Deframes SYNC/LEN/payload/CHK byte stream; payload is cut-through with zero latency, status one cycle after CHK.
// Payload in_ready follows out_ready; the inter-byte timer freezes while downstream stalls a presented byte.
module usb_rx_frame_parser
  import usb_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYC = 5000000,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             out_abort,
  output logic             stat_valid,
  output logic             stat_ok,
  output logic [7:0]       stat_len,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_chk_cnt,
  output logic [CNT_W-1:0] err_to_cnt
);

  localparam int              TMR_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic [7:0]       rem_q, rem_d;
  logic [7:0]       xor_q, xor_d;
  logic [7:0]       len_q, len_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             stat_valid_q, stat_valid_d;
  stat_t            stat_q, stat_d;
  logic             abort_q, abort_d;

  logic accept;
  logic stalled;
  logic inc_good, inc_chk, inc_to;

  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    out_data  = in_data;
    out_last  = 1'b0;
    if (state_q == PAYLOAD) begin
      in_ready  = out_ready;
      out_valid = in_valid;
      out_last  = (rem_q == 8'd1);
    end
  end

  assign accept  = in_valid & in_ready;
  assign stalled = (state_q == PAYLOAD) & in_valid & ~out_ready;

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    xor_d        = xor_q;
    len_d        = len_q;
    timer_d      = timer_q;
    stat_valid_d = 1'b0;
    stat_d       = '{ok: 1'b0, len: stat_q.len};
    abort_d      = 1'b0;
    inc_good     = 1'b0;
    inc_chk      = 1'b0;
    inc_to       = 1'b0;

    unique case (state_q)
      HUNT: begin
        timer_d = '0;
        if (accept && in_data == SYNC_BYTE) state_d = LEN;
      end
      LEN: begin
        if (accept) begin
          timer_d = '0;
          if (in_data == 8'd0) begin
            state_d      = HUNT;
            stat_valid_d = 1'b1;
            stat_d.len   = 8'd0;
            inc_to       = 1'b1;
          end else begin
            state_d = PAYLOAD;
            rem_d   = in_data;
            xor_d   = in_data;
            len_d   = in_data;
          end
        end
      end
      PAYLOAD: begin
        if (accept) begin
          timer_d = '0;
          xor_d   = xor_q ^ in_data;
          rem_d   = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = CHK;
        end
      end
      CHK: begin
        if (accept) begin
          timer_d      = '0;
          state_d      = HUNT;
          stat_valid_d = 1'b1;
          stat_d.ok    = (in_data == xor_q);
          stat_d.len   = len_q;
          inc_good     = (in_data == xor_q);
          inc_chk      = (in_data != xor_q);
        end
      end
      default: state_d = HUNT;
    endcase

    // An accepted byte always beats expiry; a stalled presented byte holds the timer.
    if (state_q != HUNT && !accept && !stalled) begin
      if (timer_q == TMR_LAST) begin
        state_d      = HUNT;
        timer_d      = '0;
        stat_valid_d = 1'b1;
        stat_d.ok    = 1'b0;
        stat_d.len   = (state_q == LEN) ? 8'd0 : len_q;
        abort_d      = (state_q == PAYLOAD);
        inc_to       = 1'b1;
      end else begin
        timer_d = timer_q + TMR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      rem_q        <= '0;
      xor_q        <= '0;
      len_q        <= '0;
      timer_q      <= '0;
      stat_valid_q <= 1'b0;
      stat_q       <= '0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      xor_q        <= xor_d;
      len_q        <= len_d;
      timer_q      <= timer_d;
      stat_valid_q <= stat_valid_d;
      stat_q       <= stat_d;
      abort_q      <= abort_d;
    end
  end

  assign stat_valid = stat_valid_q;
  assign stat_ok    = stat_q.ok;
  assign stat_len   = stat_q.len;
  assign out_abort  = abort_q;

  sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
    .clk(clk), .rst(rst), .inc(inc_good), .cnt(frame_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_chk_cnt (
    .clk(clk), .rst(rst), .inc(inc_chk), .cnt(err_chk_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_to_cnt (
    .clk(clk), .rst(rst), .inc(inc_to), .cnt(err_to_cnt)
  );

endmodule

// File: tb/tb_usb_rx_frame_parser.sv
// Self-checking bench for usb_rx_frame_parser: directed scenarios plus randomized frames
// checked against a frame-level reference model (expected payload/status queues, saturating counts).
module tb_usb_rx_frame_parser;

  localparam int TO = 100;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  typedef logic [7:0] bq_t[$];
  typedef logic [8:0] eq_t[$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_data = 8'h00;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [7:0]    out_data;
  logic          out_last;
  logic          out_abort;
  logic          stat_valid;
  logic          stat_ok;
  logic [7:0]    stat_len;
  logic [CW-1:0] frame_cnt;
  logic [CW-1:0] err_chk_cnt;
  logic [CW-1:0] err_to_cnt;

  int vectors = 0;
  int miscompares = 0;
  bit rdy_rand = 1'b0;

  logic [8:0] obs_out[$];
  logic [8:0] obs_stat[$];
  int obs_abort = 0;
  int abort_no_stat = 0;

  usb_rx_frame_parser #(
    .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_abort(out_abort),
    .stat_valid(stat_valid), .stat_ok(stat_ok), .stat_len(stat_len),
    .frame_cnt(frame_cnt), .err_chk_cnt(err_chk_cnt), .err_to_cnt(err_to_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid && out_ready) obs_out.push_back({out_last, out_data});
    if (stat_valid) obs_stat.push_back({stat_ok, stat_len});
    if (out_abort) begin
      obs_abort++;
      if (!stat_valid) abort_no_stat++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] frame_chk(input bq_t pl);
    logic [7:0] c = 8'(pl.size());
    foreach (pl[i]) c = c ^ pl[i];
    return c;
  endfunction

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_out.delete();
    obs_stat.delete();
    obs_abort = 0;
    abort_no_stat = 0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit done;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int n = 0; ; n++) begin
      if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      done = in_ready;
      tick();
      if (done) break;
      if (n > 500) begin
        vectors++;
        miscompares++;
        $display("FAIL send_byte: byte %02h not accepted within 500 cycles", b);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_seq(input bq_t s, input int maxgap);
    foreach (s[i]) send_byte(s[i], (maxgap == 0) ? 0 : $urandom_range(0, maxgap));
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, out_last, stat_valid, stat_ok, out_abort} !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_flags: got rdy/ov/last/sv/ok/ab=%b want 100000",
               {in_ready, out_valid, out_last, stat_valid, stat_ok, out_abort});
    end
    vectors++;
    if (stat_len !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_stat_len: got %0d want 0", stat_len);
    end
    vectors++;
    if ({frame_cnt, err_chk_cnt, err_to_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", frame_cnt, err_chk_cnt, err_to_cnt);
    end
    tick();
  endtask

  task automatic test_good_frame();
    eq_t exp_out;
    clear_obs();
    out_ready = 1'b1;
    send_seq({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03}, 0);
    repeat (3) tick();
    exp_out = {9'h011, 9'h022, 9'h133};
    vectors++;
    if (obs_out.size() !== exp_out.size()) begin
      miscompares++;
      $display("FAIL good_out_count: got %0d want %0d", obs_out.size(), exp_out.size());
    end
    foreach (exp_out[i]) if (i < obs_out.size()) begin
      vectors++;
      if (obs_out[i] !== exp_out[i]) begin
        miscompares++;
        $display("FAIL good_out[%0d]: got last/data=%03h want %03h", i, obs_out[i], exp_out[i]);
      end
    end
    vectors++;
    if (obs_stat.size() !== 1 || obs_stat[0] !== 9'h103) begin
      miscompares++;
      $display("FAIL good_stat: got %0d pulses first=%03h want 1 pulse 103", obs_stat.size(),
               (obs_stat.size() > 0) ? obs_stat[0] : 9'h0);
    end
    vectors++;
    if (frame_cnt !== CW'(1) || err_chk_cnt !== CW'(0)) begin
      miscompares++;
      $display("FAIL good_counters: got frame=%0d chk=%0d want 1/0", frame_cnt, err_chk_cnt);
    end
  endtask

  task automatic test_bad_chk();
    eq_t exp_out;
    clear_obs();
    send_seq({8'hA5, 8'h02, 8'h10, 8'h20, 8'hFF}, 0);
    repeat (3) tick();
    exp_out = {9'h010, 9'h120};
    vectors++;
    if (obs_out !== exp_out) begin
      miscompares++;
      $display("FAIL badchk_out: got %0d bytes want 010,120", obs_out.size());
    end
    vectors++;
    if (obs_stat.size() !== 1 || obs_stat[0] !== 9'h002) begin
      miscompares++;
      $display("FAIL badchk_stat: got %0d pulses first=%03h want 1 pulse 002", obs_stat.size(),
               (obs_stat.size() > 0) ? obs_stat[0] : 9'h0);
    end
    vectors++;
    if (frame_cnt !== CW'(1) || err_chk_cnt !== CW'(1)) begin
      miscompares++;
      $display("FAIL badchk_counters: got frame=%0d chk=%0d want 1/1", frame_cnt, err_chk_cnt);
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    clear_obs();
    send_seq({8'h00, 8'h7E, 8'hA5, 8'h01}, 0);
    // Stall longer than the timeout so a non-frozen timer would expire.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    for (int c = 0; c < TO + 20; c++) begin
      @(negedge clk);
      if (!(out_valid && !in_ready && out_data == 8'hA5 && out_last)) bad++;
      tick();
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL bp_stall_outputs: got %0d bad stall cycles want 0", bad);
    end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release_ready: got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    send_byte(8'hA4, 0);
    repeat (3) tick();
    vectors++;
    if (obs_out.size() !== 1 || obs_out[0] !== 9'h1A5) begin
      miscompares++;
      $display("FAIL bp_out: got %0d bytes first=%03h want 1 byte 1A5", obs_out.size(),
               (obs_out.size() > 0) ? obs_out[0] : 9'h0);
    end
    vectors++;
    if (obs_stat.size() !== 1 || obs_stat[0] !== 9'h101 || obs_abort !== 0) begin
      miscompares++;
      $display("FAIL bp_stat: got %0d pulses aborts=%0d want 1 pulse 101 no abort", obs_stat.size(), obs_abort);
    end
    vectors++;
    if (frame_cnt !== CW'(2) || err_to_cnt !== CW'(0)) begin
      miscompares++;
      $display("FAIL bp_counters: got frame=%0d to=%0d want 2/0", frame_cnt, err_to_cnt);
    end
  endtask

  task automatic test_timeout();
    int hit = 0;
    bit abort_seen = 1'b0;
    logic [8:0] st = 9'h0;
    eq_t exp_out;
    clear_obs();
    send_seq({8'hA5, 8'h04, 8'h01, 8'h02}, 0);
    for (int k = 1; k <= TO + 30; k++) begin
      @(negedge clk);
      if (stat_valid) begin
        hit = k;
        abort_seen = out_abort;
        st = {stat_ok, stat_len};
        break;
      end
    end
    tick();
    vectors++;
    if (hit < TO + 1 || hit > TO + 2) begin
      miscompares++;
      $display("FAIL to_latency: got stat at idle cycle %0d want %0d..%0d", hit, TO + 1, TO + 2);
    end
    vectors++;
    if (abort_seen !== 1'b1 || abort_no_stat !== 0) begin
      miscompares++;
      $display("FAIL to_abort_align: got abort=%b stray=%0d want 1/0", abort_seen, abort_no_stat);
    end
    vectors++;
    if (st !== 9'h004) begin
      miscompares++;
      $display("FAIL to_stat: got ok/len=%03h want 004", st);
    end
    exp_out = {9'h001, 9'h002};
    vectors++;
    if (obs_out !== exp_out) begin
      miscompares++;
      $display("FAIL to_out: got %0d bytes want 001,002", obs_out.size());
    end
    vectors++;
    if (err_to_cnt !== CW'(1)) begin
      miscompares++;
      $display("FAIL to_counter: got %0d want 1", err_to_cnt);
    end
    clear_obs();
    send_seq({8'hA5, 8'h01, 8'h5A, 8'h5B}, 0);
    repeat (3) tick();
    vectors++;
    if (obs_stat.size() !== 1 || obs_stat[0] !== 9'h101 || obs_out.size() !== 1) begin
      miscompares++;
      $display("FAIL to_recover: got %0d stat %0d out want 1 pulse 101 and 1 byte", obs_stat.size(), obs_out.size());
    end
    vectors++;
    if (frame_cnt !== CW'(3)) begin
      miscompares++;
      $display("FAIL to_recover_cnt: got %0d want 3", frame_cnt);
    end
  endtask

  task automatic test_len_zero_sat();
    int okp = 0;
    do_reset();
    clear_obs();
    for (int r = 0; r < 5; r++) send_seq({8'hA5, 8'h00}, 1);
    repeat (3) tick();
    foreach (obs_stat[i]) if (obs_stat[i] === 9'h000) okp++;
    vectors++;
    if (obs_stat.size() !== 5 || okp !== 5) begin
      miscompares++;
      $display("FAIL len0_stats: got %0d pulses (%0d with ok=0 len=0) want 5", obs_stat.size(), okp);
    end
    vectors++;
    if (err_to_cnt !== CW'(CMAX)) begin
      miscompares++;
      $display("FAIL len0_saturate: got %0d want %0d", err_to_cnt, CMAX);
    end
    vectors++;
    if (frame_cnt !== CW'(0) || obs_out.size() !== 0) begin
      miscompares++;
      $display("FAIL len0_side: got frame=%0d out=%0d want 0/0", frame_cnt, obs_out.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    eq_t exp_out;
    send_seq({8'hA5, 8'h05, 8'hB0, 8'hB1}, 0);
    clear_obs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    vectors++;
    if (obs_stat.size() !== 0 || obs_abort !== 0) begin
      miscompares++;
      $display("FAIL rstmid_pulses: got %0d stat %0d abort want 0/0", obs_stat.size(), obs_abort);
    end
    vectors++;
    if ({frame_cnt, err_chk_cnt, err_to_cnt} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_counters: got %0d/%0d/%0d want 0/0/0", frame_cnt, err_chk_cnt, err_to_cnt);
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h33;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_hunt: got ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clear_obs();
    send_seq({8'hA5, 8'h02, 8'hC3, 8'hA5, 8'h64}, 0);
    repeat (3) tick();
    exp_out = {9'h0C3, 9'h1A5};
    vectors++;
    if (obs_out !== exp_out || obs_stat.size() !== 1 || obs_stat[0] !== 9'h102) begin
      miscompares++;
      $display("FAIL rstmid_next_frame: got %0d bytes %0d stats want 0C3,1A5 and stat 102",
               obs_out.size(), obs_stat.size());
    end
  endtask

  task automatic test_back_to_back();
    eq_t exp_stat;
    do_reset();
    clear_obs();
    send_seq({8'hA5, 8'h01, 8'h10, 8'h11, 8'hA5, 8'h02, 8'h01, 8'h02, 8'h01}, 0);
    repeat (3) tick();
    exp_stat = {9'h101, 9'h102};
    vectors++;
    if (obs_stat !== exp_stat || frame_cnt !== CW'(2)) begin
      miscompares++;
      $display("FAIL b2b_stats: got %0d pulses frame=%0d want 101,102 and 2", obs_stat.size(), frame_cnt);
    end
  endtask

  task automatic test_random();
    eq_t exp_out, exp_stat;
    int n_good = 0, n_bad = 0, n_to = 0, errs = 0;
    do_reset();
    clear_obs();
    rdy_rand = 1'b1;
    for (int f = 0; f < 40; f++) begin
      bq_t pl, s;
      logic [7:0] chk, g;
      int ng = $urandom_range(0, 2);
      for (int i = 0; i < ng; i++) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h5A;
        s.push_back(g);
      end
      s.push_back(8'hA5);
      if ($urandom_range(0, 9) == 0) begin
        s.push_back(8'h00);
        exp_stat.push_back(9'h000);
        n_to++;
      end else begin
        int len = $urandom_range(1, 8);
        for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));
        chk = frame_chk(pl);
        if ($urandom_range(0, 9) < 3) chk = chk ^ 8'(1 << $urandom_range(0, 7));
        s.push_back(8'(len));
        foreach (pl[i]) begin
          s.push_back(pl[i]);
          exp_out.push_back({(i == len - 1), pl[i]});
        end
        s.push_back(chk);
        if (chk == frame_chk(pl)) begin
          exp_stat.push_back({1'b1, 8'(len)});
          n_good++;
        end else begin
          exp_stat.push_back({1'b0, 8'(len)});
          n_bad++;
        end
      end
      send_seq(s, 3);
    end
    rdy_rand = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    vectors++;
    if (obs_out.size() !== exp_out.size() || obs_stat.size() !== exp_stat.size()) begin
      miscompares++;
      $display("FAIL rand_counts: got out=%0d stat=%0d want out=%0d stat=%0d",
               obs_out.size(), obs_stat.size(), exp_out.size(), exp_stat.size());
    end
    foreach (exp_out[i]) if (i < obs_out.size() && obs_out[i] !== exp_out[i]) errs++;
    foreach (exp_stat[i]) if (i < obs_stat.size() && obs_stat[i] !== exp_stat[i]) errs++;
    vectors++;
    if (errs !== 0) begin
      miscompares++;
      $display("FAIL rand_stream: got %0d differing out/stat entries want 0", errs);
    end
    vectors++;
    if (frame_cnt !== CW'(sat(n_good)) || err_chk_cnt !== CW'(sat(n_bad)) ||
        err_to_cnt !== CW'(sat(n_to)) || obs_abort !== 0) begin
      miscompares++;
      $display("FAIL rand_counters: got %0d/%0d/%0d abort=%0d want %0d/%0d/%0d abort=0",
               frame_cnt, err_chk_cnt, err_to_cnt, obs_abort, sat(n_good), sat(n_bad), sat(n_to));
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_backpressure();
    test_timeout();
    test_len_zero_sat();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
